// File: rtl/efx_fifo_pkg.sv
// Shared definitions for the FIFO read/write controllers.
// States, mode names, pointer width and Gray-code helpers.
package efx_fifo_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_VALID = 1'b1
  } rd_state_e;

  localparam string MODE_STANDARD = "STANDARD";
  localparam string MODE_FWFT     = "FWFT";

  function automatic int depth2width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/efx_fifo_rd_ctl_if.sv
// Read-side bundle: consumer handshake, RAM port and flag feedback.
// slave = read controller, master = surrounding FIFO / consumer.
interface efx_fifo_rd_ctl_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) ();

  logic                  rd_en_i;
  logic                  empty_i;
  logic [DATA_WIDTH-1:0] ram_rdata_i;
  logic [ADDR_WIDTH-1:0] rd_adr_o;
  logic [ADDR_WIDTH-1:0] rd_adr_gray_o;
  logic                  rd_ram_o;
  logic [DATA_WIDTH-1:0] rdata_o;
  logic                  rvalid_o;
  logic                  read_last_o;
  logic                  underflow_o;

  modport slave (
    input  rd_en_i, empty_i, ram_rdata_i,
    output rd_adr_o, rd_adr_gray_o, rd_ram_o,
    output rdata_o, rvalid_o, read_last_o,
    output underflow_o
  );

  modport master (
    output rd_en_i, empty_i, ram_rdata_i,
    input  rd_adr_o, rd_adr_gray_o, rd_ram_o,
    input  rdata_o, rvalid_o, read_last_o,
    input  underflow_o
  );

endinterface

// File: rtl/efx_fifo_bin2gray.sv
// Binary to Gray converter for FIFO pointers (shared by both sides).
// Widths above 32 bits are not supported by the package helper.
module efx_fifo_bin2gray
  import efx_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic [ADDR_WIDTH-1:0] bin_i,
  output logic [ADDR_WIDTH-1:0] gray_o
);

  logic [31:0] gray_w;

  assign gray_w = bin2gray(32'(bin_i));
  assign gray_o = gray_w[ADDR_WIDTH-1:0];

endmodule

// File: rtl/efx_fifo_rd_ctl.sv
// FIFO read controller: read pointer, RAM strobe, STANDARD/FWFT output.
// Define EFX_FIFO_RD_GRAY_EN for a registered Gray pointer (pow2 DEPTH).
module efx_fifo_rd_ctl
  import efx_fifo_pkg::*;
#(
  parameter int    DEPTH      = 1024,
  parameter int    ADDR_WIDTH = depth2width(DEPTH),
  parameter int    DATA_WIDTH = 32,
  parameter string MODE       = "STANDARD"
) (
  input logic              clk_i,
  input logic              a_rst_i,
  efx_fifo_rd_ctl_if.slave rd
);

  localparam bit FWFT = (MODE == MODE_FWFT);
  localparam logic [ADDR_WIDTH-1:0] LAST =
    ADDR_WIDTH'(DEPTH - 1);

  rd_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic                  rvalid_q, rvalid_d;
  logic                  unf_q, unf_d;
  logic                  rd_ram;
  logic                  read_last;
  logic [DATA_WIDTH-1:0] rdata;

  always_ff @(posedge clk_i or posedge a_rst_i) begin
    if (a_rst_i) begin
      state_q  <= ST_IDLE;
      adr_q    <= '0;
      rvalid_q <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      adr_q    <= adr_d;
      rvalid_q <= rvalid_d;
      unf_q    <= unf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (FWFT) begin
      unique case (state_q)
        ST_IDLE:
          if (!rd.empty_i) state_d = ST_VALID;
        ST_VALID:
          if (rd.rd_en_i && rd.empty_i) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    rd_ram    = 1'b0;
    read_last = 1'b0;
    unf_d     = 1'b0;
    if (FWFT) begin
      unique case (state_q)
        ST_IDLE: begin
          rd_ram = !rd.empty_i;
          unf_d  = rd.rd_en_i;
        end
        ST_VALID: begin
          rd_ram    = rd.rd_en_i && !rd.empty_i;
          read_last = rd.rd_en_i && rd.empty_i;
        end
        default: ;
      endcase
    end else begin
      rd_ram = rd.rd_en_i && !rd.empty_i;
      unf_d  = rd.rd_en_i && rd.empty_i;
    end
  end

  // FWFT valid tracks the staged-word state; STANDARD is the delayed strobe.
  always_comb begin
    rvalid_d = FWFT ? (state_d == ST_VALID) : rd_ram;
    adr_d    = adr_q;
    if (rd_ram) adr_d = (adr_q == LAST) ? '0 : adr_q + 1'b1;
  end

  assign rdata          = rd.ram_rdata_i;
  assign rd.rdata_o     = rdata;
  assign rd.rd_ram_o    = rd_ram && !a_rst_i;
  assign rd.rd_adr_o    = adr_q;
  assign rd.rvalid_o    = rvalid_q;
  assign rd.underflow_o = unf_q;
  assign rd.read_last_o = read_last;

`ifdef EFX_FIFO_RD_GRAY_EN
  if ((DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
    $error("efx_fifo_rd_ctl: Gray pointer needs power-of-two DEPTH");
  end

  logic [ADDR_WIDTH-1:0] gray_q, gray_d;

  efx_fifo_bin2gray #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_bin2gray (
    .bin_i (adr_d),
    .gray_o(gray_d)
  );

  always_ff @(posedge clk_i or posedge a_rst_i) begin
    if (a_rst_i) gray_q <= '0;
    else         gray_q <= gray_d;
  end

  assign rd.rd_adr_gray_o = gray_q;
`else
  assign rd.rd_adr_gray_o = adr_q;
`endif

endmodule

// File: tb/tb_efx_fifo_rd_ctl.sv
// Bench for efx_fifo_rd_ctl: STANDARD/16, FWFT/16 and STANDARD/12 instances
// driven in lockstep against a word-count / staged-word reference model.
module tb_efx_fifo_rd_ctl;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  efx_fifo_rd_ctl_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) b0 ();
  efx_fifo_rd_ctl_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) b1 ();
  efx_fifo_rd_ctl_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) b2 ();

  efx_fifo_rd_ctl #(.DEPTH(16), .DATA_WIDTH(32), .MODE("STANDARD")) u_s16 (
    .clk_i(clk), .a_rst_i(rst), .rd(b0));
  efx_fifo_rd_ctl #(.DEPTH(16), .DATA_WIDTH(32), .MODE("FWFT")) u_f16 (
    .clk_i(clk), .a_rst_i(rst), .rd(b1));
  efx_fifo_rd_ctl #(.DEPTH(12), .DATA_WIDTH(32), .MODE("STANDARD")) u_s12 (
    .clk_i(clk), .a_rst_i(rst), .rd(b2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [3][16];
  int depth [3] = '{16, 16, 12};
  bit fwft  [3] = '{1'b0, 1'b1, 1'b0};

  // registered RAM read ports: load on strobe, hold otherwise
  always @(posedge clk) begin
    if (b0.rd_ram_o) b0.ram_rdata_i <= mem[0][b0.rd_adr_o];
    if (b1.rd_ram_o) b1.ram_rdata_i <= mem[1][b1.rd_adr_o];
    if (b2.rd_ram_o) b2.ram_rdata_i <= mem[2][b2.rd_adr_o];
  end

  // reference model: unread words, next address, staged / pending word
  int level    [3];
  int ptr      [3];
  bit staged   [3];
  int stg_adr  [3];
  bit pend     [3];
  int pend_adr [3];
  bit unf_n    [3];

  typedef struct {
    logic [31:0] adr;
    logic [31:0] gray;
    logic        strobe;
    logic        rvalid;
    logic        unf;
    logic        last;
    logic [31:0] rdata;
  } obs_t;

  function automatic obs_t get_obs(input int i);
    obs_t o;
    case (i)
      0: o = '{32'(b0.rd_adr_o), 32'(b0.rd_adr_gray_o), b0.rd_ram_o,
               b0.rvalid_o, b0.underflow_o, b0.read_last_o, b0.rdata_o};
      1: o = '{32'(b1.rd_adr_o), 32'(b1.rd_adr_gray_o), b1.rd_ram_o,
               b1.rvalid_o, b1.underflow_o, b1.read_last_o, b1.rdata_o};
      default:
         o = '{32'(b2.rd_adr_o), 32'(b2.rd_adr_gray_o), b2.rd_ram_o,
               b2.rvalid_o, b2.underflow_o, b2.read_last_o, b2.rdata_o};
    endcase
    return o;
  endfunction

  task automatic drive(input int i, input bit ren, input bit emp);
    case (i)
      0: begin b0.rd_en_i = ren; b0.empty_i = emp; end
      1: begin b1.rd_en_i = ren; b1.empty_i = emp; end
      default: begin b2.rd_en_i = ren; b2.empty_i = emp; end
    endcase
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_gray(input int p);
`ifdef EFX_FIFO_RD_GRAY_EN
    return p ^ (p >> 1);
`else
    return p;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      ptr[i] = 0; staged[i] = 0; pend[i] = 0; unf_n[i] = 0;
    end
  endtask

  task automatic take(input int i);
    ptr[i] = (ptr[i] + 1) % depth[i];
    level[i]--;
  endtask

  // one clock cycle; ren bit i drives instance i
  task automatic cyc(input bit [2:0] ren);
    obs_t o;
    bit   e, s, l;
    @(negedge clk);
    for (int i = 0; i < 3; i++) drive(i, ren[i], level[i] == 0);
    #1;
    for (int i = 0; i < 3; i++) begin
      o = get_obs(i);
      e = (level[i] == 0);
      if (fwft[i]) begin
        s = staged[i] ? (ren[i] && !e) : !e;
        l = staged[i] && ren[i] && e;
        chk($sformatf("rvalid%0d", i), 64'(o.rvalid), 64'(staged[i]));
        if (staged[i])
          chk($sformatf("rdata%0d", i), 64'(o.rdata), 64'(mem[i][stg_adr[i]]));
      end else begin
        s = ren[i] && !e;
        l = 1'b0;
        chk($sformatf("rvalid%0d", i), 64'(o.rvalid), 64'(pend[i]));
        if (pend[i])
          chk($sformatf("rdata%0d", i), 64'(o.rdata), 64'(mem[i][pend_adr[i]]));
      end
      chk($sformatf("adr%0d", i), 64'(o.adr), 64'(ptr[i]));
      chk($sformatf("gray%0d", i), 64'(o.gray), 64'(exp_gray(ptr[i])));
      chk($sformatf("strobe%0d", i), 64'(o.strobe), 64'(s));
      chk($sformatf("last%0d", i), 64'(o.last), 64'(l));
      chk($sformatf("unf%0d", i), 64'(o.unf), 64'(unf_n[i]));
      if (fwft[i]) begin
        unf_n[i] = !staged[i] && ren[i];
        if (!staged[i]) begin
          if (!e) begin staged[i] = 1; stg_adr[i] = ptr[i]; take(i); end
        end else if (ren[i]) begin
          if (!e) begin stg_adr[i] = ptr[i]; take(i); end
          else staged[i] = 0;
        end
      end else begin
        unf_n[i] = ren[i] && e;
        pend[i]  = s;
        if (s) begin pend_adr[i] = ptr[i]; take(i); end
      end
    end
    @(posedge clk);
  endtask

  task automatic chk_all_reset(input string tag);
    obs_t o;
    for (int i = 0; i < 3; i++) begin
      o = get_obs(i);
      chk($sformatf("%s_adr%0d", tag, i), 64'(o.adr), 64'd0);
      chk($sformatf("%s_gray%0d", tag, i), 64'(o.gray), 64'd0);
      chk($sformatf("%s_strobe%0d", tag, i), 64'(o.strobe), 64'd0);
      chk($sformatf("%s_rvalid%0d", tag, i), 64'(o.rvalid), 64'd0);
      chk($sformatf("%s_unf%0d", tag, i), 64'(o.unf), 64'd0);
      chk($sformatf("%s_last%0d", tag, i), 64'(o.last), 64'd0);
    end
  endtask

  initial begin
    int room;
    errors = 0;
    checks = 0;
    for (int i = 0; i < 3; i++) begin
      level[i] = 0;
      for (int a = 0; a < 16; a++) mem[i][a] = $urandom;
    end
    model_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) drive(i, 1'b0, 1'b1);
    #1;
    chk_all_reset("por");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // STANDARD: four words, four reads, then underflow on empty
    level[0] = 4;
    repeat (4) cyc(3'b001);
    cyc(3'b000);
    chk("std_adr_after4", 64'(b0.rd_adr_o), 64'd4);
    cyc(3'b001);
    cyc(3'b000);

    // FWFT: idle until data lands, prefetch, hold, then drain three
    repeat (4) cyc(3'b000);
    level[1] = 3;
    repeat (4) cyc(3'b000);
    repeat (3) cyc(3'b010);
    cyc(3'b010);
    cyc(3'b000);

    // DEPTH 12 wrap: thirteen reads
    level[2] = 8;
    repeat (8) cyc(3'b100);
    level[2] = level[2] + 5;
    repeat (5) cyc(3'b100);
    cyc(3'b000);
    chk("wrap12_adr", 64'(b2.rd_adr_o), 64'd1);

    // FWFT reaches address 5 with a word staged, then async reset
    level[1] = level[1] + 3;
    cyc(3'b000);
    cyc(3'b010);
    @(negedge clk);
    #1;
    chk("pre_rst_adr", 64'(b1.rd_adr_o), 64'd5);
    chk("pre_rst_rvalid", 64'(b1.rvalid_o), 64'd1);
    #1;
    rst = 1'b1;
    #1;
    chk_all_reset("mid");
    @(posedge clk);
    #3;
    rst = 1'b0;
    model_reset();
    repeat (3) cyc(3'b000);
    cyc(3'b010);

    // random traffic with random refills
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 3; i++) begin
        room = depth[i] - level[i] - (staged[i] ? 1 : 0);
        if ($urandom_range(0, 3) == 0 && room > 0)
          level[i] = level[i] + $urandom_range(0, room);
      end
      cyc(3'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
